// File: rtl/rsp_pkg.sv
// rsp_pkg: shared states, RFIR mode encodings, widths and tap-count helper for the coefficient sequencer
package rsp_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, ZERO, SETTLE, RUN} state_t;
  localparam logic [1:0] RFIR_MODE_24   = 2'b00;
  localparam logic [1:0] RFIR_MODE_48   = 2'b01;
  localparam logic [1:0] RFIR_MODE_72   = 2'b10;
  localparam logic [1:0] RFIR_MODE_RSVD = 2'b11;
  localparam int COEFF_W = 16;
  localparam int ADDR_W = 7;
  function automatic logic [7:0] tap_count(input logic [1:0] mode);
    return mode == RFIR_MODE_24 ? 8'd24 : mode == RFIR_MODE_48 ? 8'd48 : 8'd72;
  endfunction
endpackage

// File: rtl/rfir_settle_timer.sv
// rfir_settle_timer: loadable down-counter with a terminal-count pulse on its last counted cycle
// Ports: clk_m/reset clock and async reset; load reloads CYC; en counts down; tc high in the final enabled cycle.
module rfir_settle_timer #(
  parameter int CYC = 8
) (
  input  logic clk_m,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic tc
);
  localparam int W = $clog2(CYC + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk_m or posedge reset)
    if (reset) cnt <= '0;
    else if (load) cnt <= W'(CYC);
    else if (en && cnt != '0) cnt <= cnt - 1'b1;
  assign tc = en && cnt == W'(1);
endmodule

// File: rtl/rfir_coeff_sequencer.sv
// rfir_coeff_sequencer: loads host coefficients into RFIR RAM, zero-fills unused taps, flushes, then enables the RFIR
// Ports: cfg_start/cfg_mode/cfg_abort control; coeff_valid/coeff_data/coeff_ready host stream;
//        ram_wr_en/ram_addr/ram_coeff RAM write port; en_rfir/mode_rfir RFIR control; busy/done/err status.
module rfir_coeff_sequencer #(
  parameter int MAX_TAPS = 72,
  parameter int SETTLE_CYC = 8,
  parameter int COEFF_W = 16
) (
  input  logic               clk_m,
  input  logic               reset,
  input  logic               cfg_start,
  input  logic [1:0]         cfg_mode,
  input  logic               cfg_abort,
  input  logic               coeff_valid,
  input  logic [COEFF_W-1:0] coeff_data,
  output logic               coeff_ready,
  output logic               ram_wr_en,
  output logic [6:0]         ram_addr,
  output logic [COEFF_W-1:0] ram_coeff,
  output logic               en_rfir,
  output logic [1:0]         mode_rfir,
  output logic               busy,
  output logic               done,
  output logic               err
);
  import rsp_pkg::*;
  state_t state, nxt;
  logic [1:0] mode_q;
  logic [7:0] cnt, n_taps;
  logic idle_run, accept, reject, abort, beat, wr, last_beat, zero_last, settle_load, tc;
  assign n_taps = tap_count(mode_q);
  assign idle_run = state == IDLE || state == RUN;
  assign accept = idle_run && cfg_start && cfg_mode != RFIR_MODE_RSVD;
  assign reject = idle_run && cfg_start && cfg_mode == RFIR_MODE_RSVD;
  assign abort = busy && cfg_abort;
  assign beat = coeff_ready && coeff_valid;
  // A handshaken beat is always written, even alongside an abort; zero-fill stops at once on abort.
  assign wr = beat || (state == ZERO && !cfg_abort);
  assign last_beat = beat && cnt == n_taps - 8'd1;
  assign zero_last = state == ZERO && cnt == 8'(MAX_TAPS - 1);
  // Timer is armed on the edge that registers the final write, so SETTLE spans exactly SETTLE_CYC cycles.
  assign settle_load = !abort && ((last_beat && n_taps >= 8'(MAX_TAPS)) || zero_last);
  rfir_settle_timer #(.CYC(SETTLE_CYC)) u_timer (
    .clk_m(clk_m),
    .reset(reset),
    .load(settle_load),
    .en(state == SETTLE),
    .tc(tc)
  );
  always_ff @(posedge clk_m or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = abort ? IDLE : accept ? LOAD : settle_load ? SETTLE : last_beat ? ZERO :
          (state == SETTLE && tc) ? RUN : state;
    coeff_ready = state == LOAD;
    busy = state == LOAD || state == ZERO || state == SETTLE;
    en_rfir = state == RUN;
  end
  always_ff @(posedge clk_m or posedge reset)
    if (reset) begin
      ram_wr_en <= 1'b0;
      ram_addr <= '0;
      ram_coeff <= '0;
      cnt <= '0;
      mode_q <= RFIR_MODE_24;
      mode_rfir <= RFIR_MODE_24;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      ram_wr_en <= wr;
      ram_addr <= wr ? cnt[6:0] : ram_addr;
      ram_coeff <= beat ? coeff_data : wr ? '0 : ram_coeff;
      cnt <= accept ? 8'd0 : wr ? cnt + 8'd1 : cnt;
      mode_q <= accept ? cfg_mode : mode_q;
      done <= nxt == RUN && state != RUN;
      mode_rfir <= (nxt == RUN && state != RUN) ? mode_q : mode_rfir;
      err <= reject || abort;
    end
endmodule

// File: tb/tb_rfir_coeff_sequencer.sv
// tb_rfir_coeff_sequencer: randomized self-checking bench against a tap-list/latency reference model
module tb_rfir_coeff_sequencer;
  localparam int MAX_TAPS = 72;
  localparam int SETTLE_CYC = 8;
  localparam int COEFF_W = 16;
  logic clk_m = 0, reset = 1, cfg_start = 0, cfg_abort = 0, coeff_valid = 0;
  logic [1:0] cfg_mode = 0;
  logic [COEFF_W-1:0] coeff_data = 0;
  logic coeff_ready, ram_wr_en, en_rfir, busy, done, err;
  logic [6:0] ram_addr;
  logic [COEFF_W-1:0] ram_coeff;
  logic [1:0] mode_rfir;
  int total = 0, bad = 0, cyc = 0, n_done = 0, n_err = 0, done_cyc = 0;
  int wa[$], wd[$], wc[$];
  logic [COEFF_W-1:0] cur[$];

  rfir_coeff_sequencer #(.MAX_TAPS(MAX_TAPS), .SETTLE_CYC(SETTLE_CYC), .COEFF_W(COEFF_W)) dut (
    .clk_m(clk_m), .reset(reset), .cfg_start(cfg_start), .cfg_mode(cfg_mode), .cfg_abort(cfg_abort),
    .coeff_valid(coeff_valid), .coeff_data(coeff_data), .coeff_ready(coeff_ready),
    .ram_wr_en(ram_wr_en), .ram_addr(ram_addr), .ram_coeff(ram_coeff),
    .en_rfir(en_rfir), .mode_rfir(mode_rfir), .busy(busy), .done(done), .err(err)
  );

  always #5 clk_m = ~clk_m;

  always @(negedge clk_m) begin
    cyc++;
    if (ram_wr_en) begin
      wa.push_back(int'(ram_addr));
      wd.push_back(int'(ram_coeff));
      wc.push_back(cyc);
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (err) n_err++;
  end

  task automatic chk(string tag, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(int k = 1);
    repeat (k) @(posedge clk_m);
    #1;
  endtask

  task automatic fill(int n, bit ramp);
    cur.delete();
    for (int k = 0; k < n; k++) cur.push_back(ramp ? COEFF_W'(k + 1) : COEFF_W'($urandom));
  endtask

  task automatic load(int mode, int vmode, bit spam);
    int i = 0, guard = 0;
    bit tog = 0;
    cfg_start = 1;
    cfg_mode = 2'(mode);
    step();
    cfg_start = 0;
    while (i < cur.size() && guard < 2000) begin
      guard++;
      tog = !tog;
      coeff_valid = vmode == 0 ? 1'b1 : vmode == 1 ? tog : ($urandom_range(3) != 0);
      coeff_data = coeff_valid ? cur[i] : COEFF_W'($urandom);
      cfg_start = spam && $urandom_range(1) == 1;
      cfg_mode = 2'($urandom);
      if (coeff_valid && coeff_ready) i++;
      step();
    end
    coeff_valid = 0;
    cfg_start = 0;
    chk("beats_accepted", i, cur.size());
    chk("ready_after_load", coeff_ready, 0);
  endtask

  task automatic check_load(int mode, int bw, int d0, int e0);
    int n = cur.size();
    int g = 0;
    while (n_done == d0 && g < 400) begin
      step();
      g++;
    end
    chk("done_seen", n_done > d0, 1);
    step(2);
    chk("wr_count", wa.size() - bw, MAX_TAPS);
    if (wa.size() - bw >= MAX_TAPS) begin
      for (int k = 0; k < MAX_TAPS; k++) begin
        chk("wr_addr", wa[bw+k], k);
        chk("wr_data", wd[bw+k], k < n ? int'(cur[k]) : 0);
      end
      for (int k = n - 1; k < MAX_TAPS; k++) chk("zero_gapless", wc[bw+k] - wc[bw+n-1], k - n + 1);
      chk("done_latency", done_cyc - wc[bw+MAX_TAPS-1], SETTLE_CYC);
    end
    chk("done_pulses", n_done - d0, 1);
    chk("done_low", done, 0);
    chk("en_rfir", en_rfir, 1);
    chk("mode_rfir", mode_rfir, mode);
    chk("busy_run", busy, 0);
    chk("no_err", n_err - e0, 0);
  endtask

  task automatic full_load(int mode, int vmode, bit spam, bit ramp);
    int bw, d0, e0;
    fill(24 * (mode + 1), ramp);
    bw = wa.size();
    d0 = n_done;
    e0 = n_err;
    load(mode, vmode, spam);
    check_load(mode, bw, d0, e0);
  endtask

  initial begin
    int bw, d0, e0, mode;
    step(3);
    chk("rst_wr_en", ram_wr_en, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_coeff", ram_coeff, 0);
    chk("rst_en", en_rfir, 0);
    chk("rst_mode", mode_rfir, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", coeff_ready, 0);
    reset = 0;
    step(2);
    full_load(2, 0, 0, 1);
    full_load(0, 1, 0, 0);
    full_load(1, 2, 0, 0);
    bw = wa.size();
    e0 = n_err;
    cfg_start = 1;
    cfg_mode = 2'b11;
    step();
    cfg_start = 0;
    step(4);
    chk("rsvd_err", n_err - e0, 1);
    chk("rsvd_en", en_rfir, 1);
    chk("rsvd_mode", mode_rfir, 1);
    chk("rsvd_writes", wa.size() - bw, 0);
    chk("rsvd_busy", busy, 0);
    fill(48, 0);
    bw = wa.size();
    d0 = n_done;
    e0 = n_err;
    cfg_start = 1;
    cfg_mode = 2'b01;
    step();
    cfg_start = 0;
    chk("start_en_drop", en_rfir, 0);
    for (int i = 0; i < 10; i++) begin
      coeff_valid = 1;
      coeff_data = cur[i];
      step();
    end
    coeff_valid = 0;
    cfg_abort = 1;
    step();
    cfg_abort = 0;
    step(20);
    chk("abort_writes", wa.size() - bw, 10);
    for (int k = 0; k < 10 && bw + k < wa.size(); k++) begin
      chk("abort_addr", wa[bw+k], k);
      chk("abort_data", wd[bw+k], int'(cur[k]));
    end
    chk("abort_err", n_err - e0, 1);
    chk("abort_done", n_done - d0, 0);
    chk("abort_busy", busy, 0);
    chk("abort_en", en_rfir, 0);
    chk("abort_ready", coeff_ready, 0);
    full_load(1, 2, 1, 0);
    repeat (4) begin
      mode = $urandom_range(2);
      full_load(mode, int'($urandom_range(2)), 1'($urandom_range(1)), 0);
    end
    fill(24, 0);
    d0 = n_done;
    load(0, 0, 0);
    step(5);
    chk("zero_wr_before_rst", ram_wr_en, 1);
    chk("zero_busy_before_rst", busy, 1);
    #2 reset = 1;
    #1;
    chk("async_wr_en", ram_wr_en, 0);
    chk("async_busy", busy, 0);
    chk("async_en", en_rfir, 0);
    step(2);
    reset = 0;
    step(3);
    chk("post_rst_ready", coeff_ready, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_done", n_done - d0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
